// File: rtl/arp_crypto_pkg.sv
// Shared constants and types for the ARP key inserter/verifier pair on the 256-bit AXI-Stream path.
package arp_crypto_pkg;

    localparam int unsigned DATA_W    = 256;
    localparam int unsigned KEEP_W    = DATA_W / 8;
    localparam int unsigned USER_W    = 128;

    localparam logic [15:0] ARP_ETHERTYPE_LE = 16'h0608;
    localparam int unsigned TYPE_HIGH = 111;
    localparam int unsigned TYPE_LOW  = 96;
    localparam int unsigned KEY_HIGH  = 207;
    localparam int unsigned KEY_LOW   = 80;
    localparam int unsigned KEY_WIDTH = 128;

    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        CHK      = 6'b000010,
        EMIT_HDR = 6'b000100,
        EMIT_KEY = 6'b001000,
        FWD      = 6'b010000,
        DROP     = 6'b100000
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KEEP_W-1:0] tkeep;
        logic [USER_W-1:0] tuser;
        logic              tlast;
    } axis_beat_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout_o whenever empty_o is low.
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned MAX_DEPTH_BITS = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             nearly_full_o,
    output logic             empty_o
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int unsigned PTR_W = MAX_DEPTH_BITS;
    localparam int unsigned CNT_W = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full          = (cnt_q == CNT_W'(DEPTH));
    assign empty_o       = (cnt_q == '0);
    assign nearly_full_o = (cnt_q >= CNT_W'(DEPTH - 1));
    assign do_wr         = wr_en_i && !full;
    assign do_rd         = rd_en_i && !empty_o;
    assign dout_o        = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

endmodule

// File: rtl/arp_crypto_verify.sv
// Receive-side ARP key check: forwards keyed ARP frames with the key zeroed, drops unkeyed or
// wrongly keyed ARP frames, and passes every other frame through untouched.
module arp_crypto_verify
    import arp_crypto_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned FIFO_DEPTH_BITS      = 2
) (
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    input  logic [KEY_WIDTH-1:0]              key_i,
    input  logic                              clear_counters,
    output logic [31:0]                       pass_count,
    output logic [31:0]                       drop_count
);

    state_t     state_q, state_d;
    axis_beat_t hold_q, hold_d;
    axis_beat_t in_beat, head, out_beat;
    logic [31:0] pass_cnt_q, pass_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        fifo_nearly_full;
    logic        fifo_empty;
    logic        pop_c;
    logic        pass_inc;
    logic        drop_inc;
    logic        head_is_arp;
    logic        key_match;
    logic [KEY_WIDTH-1:0] head_key;

    assign in_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};

    fallthrough_small_fifo #(
        .WIDTH          ($bits(axis_beat_t)),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk_i         (axis_aclk),
        .rst_n_i       (axis_resetn),
        .din_i         (in_beat),
        .wr_en_i       (s_axis_tvalid && s_axis_tready),
        .rd_en_i       (pop_c),
        .dout_o        (head),
        .nearly_full_o (fifo_nearly_full),
        .empty_o       (fifo_empty)
    );

    assign s_axis_tready = !fifo_nearly_full;
    assign head_is_arp   = (head.tdata[TYPE_HIGH:TYPE_LOW] == ARP_ETHERTYPE_LE);
    assign head_key      = head.tdata[KEY_HIGH:KEY_LOW];
    assign key_match     = (head_key == key_i);

    assign m_axis_tdata  = out_beat.tdata;
    assign m_axis_tkeep  = out_beat.tkeep;
    assign m_axis_tuser  = out_beat.tuser;
    assign m_axis_tlast  = out_beat.tlast;
    assign pass_count    = pass_cnt_q;
    assign drop_count    = drop_cnt_q;

    // Next-state, pop and egress selection.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        out_beat      = head;
        m_axis_tvalid = 1'b0;
        pop_c         = 1'b0;
        pass_inc      = 1'b0;
        drop_inc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (!head_is_arp) begin
                        m_axis_tvalid = 1'b1;
                        if (m_axis_tready) begin
                            pop_c = 1'b1;
                            if (!head.tlast) state_d = FWD;
                        end
                    end else begin
                        pop_c  = 1'b1;
                        hold_d = head;
                        if (head.tlast) drop_inc = 1'b1;
                        else            state_d  = CHK;
                    end
                end
            end
            CHK: begin
                if (!fifo_empty) begin
                    if (key_match) begin
                        state_d = EMIT_HDR;
                    end else begin
                        pop_c    = 1'b1;
                        drop_inc = 1'b1;
                        state_d  = head.tlast ? IDLE : DROP;
                    end
                end
            end
            EMIT_HDR: begin
                out_beat       = hold_q;
                out_beat.tlast = 1'b0;
                m_axis_tvalid  = 1'b1;
                if (m_axis_tready) state_d = EMIT_KEY;
            end
            EMIT_KEY: begin
                out_beat.tdata[KEY_HIGH:KEY_LOW] = '0;
                m_axis_tvalid = !fifo_empty;
                if (!fifo_empty && m_axis_tready) begin
                    pop_c    = 1'b1;
                    pass_inc = 1'b1;
                    state_d  = head.tlast ? IDLE : FWD;
                end
            end
            FWD: begin
                m_axis_tvalid = !fifo_empty;
                if (!fifo_empty && m_axis_tready) begin
                    pop_c = 1'b1;
                    if (head.tlast) state_d = IDLE;
                end
            end
            DROP: begin
                if (!fifo_empty) begin
                    pop_c = 1'b1;
                    if (head.tlast) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over a same-cycle increment; both counters wrap naturally.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_counters) begin
            pass_cnt_d = '0;
            drop_cnt_d = '0;
        end else begin
            if (pass_inc) pass_cnt_d = pass_cnt_q + 32'd1;
            if (drop_inc) drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_arp_crypto_verify.sv
// Directed bench for arp_crypto_verify: a frame-level model predicts the egress beat stream and
// counters; one monitor compares every egress handshake and checks stall stability.
module tb_arp_crypto_verify;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  k;
        logic [127:0] u;
        logic         l;
    } beat_t;

    localparam logic [127:0] KEY = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

    logic         clk = 1'b0;
    logic         axis_resetn;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tlast;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tlast;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic [127:0] key_i;
    logic         clear_counters;
    logic [31:0]  pass_count;
    logic [31:0]  drop_count;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    first_s_cyc = 0;
    int    exp_pass = 0;
    int    exp_drop = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_cyc[$];
    beat_t frm[$];
    beat_t keep_b0;
    beat_t prev_beat;
    beat_t cur_beat;
    beat_t exp_beat;
    bit    stall_prev = 1'b0;
    bit    rnd_ready  = 1'b0;
    logic  ready_lvl  = 1'b1;

    arp_crypto_verify dut (
        .axis_aclk      (clk),
        .axis_resetn    (axis_resetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .key_i          (key_i),
        .clear_counters (clear_counters),
        .pass_count     (pass_count),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Egress back-pressure: fixed level or 50% random.
    initial forever begin
        @(posedge clk);
        #1;
        m_axis_tready = rnd_ready ? ($urandom_range(0, 1) == 1) : ready_lvl;
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Monitor: every egress handshake against the model queue, plus hold-while-stalled.
    initial forever begin
        @(negedge clk);
        cur_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
        if (!axis_resetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_checks++;
                if (!m_axis_tvalid || cur_beat !== prev_beat) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%0b beat=%0h required %0h", m_axis_tvalid, cur_beat, prev_beat);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back(cur_beat);
                got_cyc.push_back(cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h, required no output", cur_beat);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if (cur_beat !== exp_beat) begin
                        n_fail++;
                        $display("FAIL egress_beat: got %0h required %0h", cur_beat, exp_beat);
                    end
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_beat  = cur_beat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = IPv4, 1 = ARP with correct key, 2 = ARP with key off by one bit.
    task automatic build(input int nbeats, input int kind);
        beat_t b;
        frm.delete();
        for (int i = 0; i < nbeats; i++) begin
            for (int w = 0; w < 8; w++) b.d[w*32 +: 32] = $urandom;
            b.k = (i == nbeats - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            b.u = {$urandom, $urandom, $urandom, $urandom};
            b.l = (i == nbeats - 1);
            if (i == 0) b.d[111:96] = (kind == 0) ? 16'h0008 : 16'h0608;
            if (i == 1 && kind == 1) b.d[207:80] = KEY;
            if (i == 1 && kind == 2) b.d[207:80] = KEY ^ 128'h1;
            frm.push_back(b);
        end
    endtask

    // Frame-level reference: what must come out and which counter must move.
    task automatic model_frame();
        beat_t b;
        if (frm[0].d[111:96] != 16'h0608) begin
            foreach (frm[i]) exp_q.push_back(frm[i]);
        end else if (frm.size() > 1 && frm[1].d[207:80] == key_i) begin
            foreach (frm[i]) begin
                b = frm[i];
                if (i == 1) b.d[207:80] = '0;
                exp_q.push_back(b);
            end
            exp_pass++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < frm.size(); i++) begin
            int waited = 0;
            bit acc = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = frm[i];
            s_axis_tvalid = 1'b1;
            while (!acc && waited < 200) begin
                @(negedge clk);
                acc = s_axis_tready;
                if (acc && i == 0) first_s_cyc = cyc;
                tick();
                waited++;
            end
            s_axis_tvalid = 1'b0;
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_timeout: beat %0d not accepted, s_ready=%0b required 1", i, s_axis_tready);
            end
        end
    endtask

    task automatic run(input int nbeats, input int kind, input bit gaps);
        build(nbeats, kind);
        model_frame();
        send_frame(gaps);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats still outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (6) tick();
    endtask

    task automatic check_cnt(input string tag);
        @(negedge clk);
        check({tag, "_pass_count"}, 256'(pass_count), 256'(exp_pass));
        check({tag, "_drop_count"}, 256'(drop_count), 256'(exp_drop));
        tick();
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        axis_resetn    = 1'b0;
        s_axis_tvalid  = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tkeep   = '0;
        s_axis_tuser   = '0;
        s_axis_tlast   = 1'b0;
        key_i          = KEY;
        clear_counters = 1'b0;
        repeat (3) tick();
        axis_resetn = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_m_valid", 256'(m_axis_tvalid), 256'(0));
        check("rst_s_ready", 256'(s_axis_tready), 256'(1));
        check("rst_pass", 256'(pass_count), 256'(0));
        check("rst_drop", 256'(drop_count), 256'(0));
        tick();

        // 1: IPv4 passes bit-identical, three cycles
        clear_log();
        run(3, 0, 1'b0);
        drain();
        check("t1_beats", 256'(got_q.size()), 256'(3));
        if (got_cyc.size() == 3) check("t1_latency", 256'(got_cyc[2] - first_s_cyc), 256'(3));
        check_cnt("t1");

        // 2: keyed ARP accepted, key zeroed, two extra cycles
        clear_log();
        run(2, 1, 1'b0);
        keep_b0 = frm[0];
        drain();
        check("t2_beats", 256'(got_q.size()), 256'(2));
        if (got_q.size() == 2) begin
            check("t2_latency", 256'(got_cyc[0] - first_s_cyc), 256'(3));
            check("t2_beat0", got_q[0].d, keep_b0.d);
            check("t2_key_zero", 256'(got_q[1].d[207:80]), 256'(0));
        end
        check("t2_pass_lit", 256'(pass_count), 256'(1));
        check_cnt("t2");

        // 3: wrong key dropped, following IPv4 intact
        run(3, 2, 1'b0);
        run(2, 0, 1'b0);
        drain();
        check("t3_drop_lit", 256'(drop_count), 256'(1));
        check_cnt("t3");

        // 4: single-beat ARP has no key, back in IDLE the next cycle
        clear_log();
        run(1, 1, 1'b0);
        run(2, 0, 1'b0);
        drain();
        if (got_cyc.size() == 2) check("t4_next_latency", 256'(got_cyc[0] - first_s_cyc), 256'(1));
        check("t4_drop_lit", 256'(drop_count), 256'(2));
        check_cnt("t4");

        // clear held across a drop increment: clear wins
        clear_counters = 1'b1;
        run(1, 1, 1'b0);
        tick();
        clear_counters = 1'b0;
        exp_pass = 0;
        exp_drop = 0;
        drain();
        check_cnt("clr");

        // 5: back-pressure fills the FIFO, then random ready with input gaps
        clear_log();
        ready_lvl = 1'b0;
        fork
            run(5, 1, 1'b1);
            begin
                repeat (20) tick();
                @(negedge clk);
                check("t5_s_ready_low", 256'(s_axis_tready), 256'(0));
                tick();
                rnd_ready = 1'b1;
            end
        join
        drain();
        if (got_q.size() == 5) check("t5_key_zero", 256'(got_q[1].d[207:80]), 256'(0));
        run(2, 0, 1'b1);
        run(4, 1, 1'b1);
        run(3, 2, 1'b1);
        run(3, 0, 1'b1);
        drain();
        rnd_ready = 1'b0;
        ready_lvl = 1'b1;
        repeat (2) tick();
        check_cnt("t5");

        // 6: reset while the header beat is presented
        ready_lvl = 1'b0;
        repeat (2) tick();
        run(2, 1, 1'b0);
        begin
            int t = 0;
            while (!m_axis_tvalid && t < 50) begin
                tick();
                t++;
            end
        end
        check("t6_hdr_valid", 256'(m_axis_tvalid), 256'(1));
        check("t6_hdr_last", 256'(m_axis_tlast), 256'(0));
        check("t6_hdr_data", m_axis_tdata, frm[0].d);
        axis_resetn = 1'b0;
        tick();
        axis_resetn = 1'b1;
        exp_q.delete();
        exp_pass = 0;
        exp_drop = 0;
        @(negedge clk);
        check("t6_valid_after_rst", 256'(m_axis_tvalid), 256'(0));
        check("t6_pass_after_rst", 256'(pass_count), 256'(0));
        check("t6_drop_after_rst", 256'(drop_count), 256'(0));
        tick();
        ready_lvl = 1'b1;
        repeat (2) tick();
        run(3, 0, 1'b0);
        run(2, 1, 1'b0);
        drain();
        check_cnt("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
